// File: rtl/parking_lot_pkg.sv
// Shared types for the parking lot occupancy monitor: per-gate FSM state
// encoding and a popcount helper for combining gate pulses.
package parking_lot_pkg;

   localparam int MAX_GATES = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      IN_A   = 3'b001,
      IN_AB  = 3'b010,
      IN_B   = 3'b011,
      OUT_B  = 3'b100,
      OUT_AB = 3'b101,
      OUT_A  = 3'b110
   } gate_state_e;

   function automatic logic [3:0] popcount8(input logic [MAX_GATES-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < MAX_GATES; i++) c = c + 4'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One two-sensor gate: direction FSM with registered enter/exit pulses.
// Optional PARKING_LOT_GATE_BLOCK_EN exposes the next-state IN_* indication.
//
// state  | meaning
// IDLE   | no car in the gate
// IN_A   | entering, outer sensor only
// IN_AB  | entering, both sensors
// IN_B   | entering, inner sensor only
// OUT_B  | leaving, inner sensor only
// OUT_AB | leaving, both sensors
// OUT_A  | leaving, outer sensor only
module parking_gate_fsm
   import parking_lot_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic enter_nxt,
   output logic exit_nxt,
`ifdef PARKING_LOT_GATE_BLOCK_EN
   output logic in_nxt,
`endif
   output logic enter,
   output logic exit
);

   gate_state_e state_q, state_d;
   logic        enter_q, exit_q;
   logic        enter_d, exit_d;

   always_comb begin
      state_d = IDLE;
      enter_d = 1'b0;
      exit_d  = 1'b0;
      case (state_q)
         IDLE:
            case ({a, b})
               2'b10:   state_d = IN_A;
               2'b01:   state_d = OUT_B;
               default: state_d = IDLE;
            endcase
         IN_A:
            case ({a, b})
               2'b11:   state_d = IN_AB;
               2'b10:   state_d = IN_A;
               default: state_d = IDLE;
            endcase
         IN_AB:
            case ({a, b})
               2'b10:   state_d = IN_A;
               2'b01:   state_d = IN_B;
               2'b11:   state_d = IN_AB;
               default: state_d = IDLE;
            endcase
         IN_B:
            case ({a, b})
               2'b11:   state_d = IN_AB;
               2'b01:   state_d = IN_B;
               2'b00:   enter_d = 1'b1;
               default: state_d = IDLE;
            endcase
         OUT_B:
            case ({a, b})
               2'b11:   state_d = OUT_AB;
               2'b01:   state_d = OUT_B;
               default: state_d = IDLE;
            endcase
         OUT_AB:
            case ({a, b})
               2'b01:   state_d = OUT_B;
               2'b10:   state_d = OUT_A;
               2'b11:   state_d = OUT_AB;
               default: state_d = IDLE;
            endcase
         OUT_A:
            case ({a, b})
               2'b11:   state_d = OUT_AB;
               2'b10:   state_d = OUT_A;
               2'b00:   exit_d  = 1'b1;
               default: state_d = IDLE;
            endcase
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         enter_q <= enter_d;
         exit_q  <= exit_d;
      end
   end

   assign enter_nxt = enter_d;
   assign exit_nxt  = exit_d;
   assign enter     = enter_q;
   assign exit      = exit_q;
`ifdef PARKING_LOT_GATE_BLOCK_EN
   assign in_nxt = (state_d == IN_A) || (state_d == IN_AB) || (state_d == IN_B);
`endif

endmodule

// File: rtl/parking_lot_occupancy.sv
// Multi-gate parking lot monitor: per-gate direction FSMs feeding a saturating
// occupancy counter with full/empty and sticky overflow/underflow flags.
// Optional PARKING_LOT_GATE_BLOCK_EN adds the per-gate entry barrier output.
module parking_lot_occupancy
   import parking_lot_pkg::*;
#(
   parameter int NUM_GATES = 2,
   parameter int CAPACITY  = 100,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_GATES-1:0] a,
   input  logic [NUM_GATES-1:0] b,
   output logic [NUM_GATES-1:0] enter,
   output logic [NUM_GATES-1:0] exit,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
`ifdef PARKING_LOT_GATE_BLOCK_EN
   output logic [NUM_GATES-1:0] gate_block,
`endif
   output logic                 underflow
);

   localparam logic signed [CNT_W+3:0] CAP_S = (CNT_W+4)'(CAPACITY);
   localparam logic [CNT_W-1:0]        CAP_C = CNT_W'(CAPACITY);

   logic [NUM_GATES-1:0] enter_nxt, exit_nxt;
`ifdef PARKING_LOT_GATE_BLOCK_EN
   logic [NUM_GATES-1:0] in_nxt;
   logic [NUM_GATES-1:0] gate_block_q, gate_block_d;
`endif

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
      parking_gate_fsm u_gate (
         .clk       (clk),
         .reset     (reset),
         .a         (a[g]),
         .b         (b[g]),
         .enter_nxt (enter_nxt[g]),
         .exit_nxt  (exit_nxt[g]),
`ifdef PARKING_LOT_GATE_BLOCK_EN
         .in_nxt    (in_nxt[g]),
`endif
         .enter     (enter[g]),
         .exit      (exit[g])
      );
   end

   logic [CNT_W-1:0]        count_q, count_d;
   logic                    full_q, full_d, empty_q, empty_d;
   logic                    overflow_q, overflow_d, underflow_q, underflow_d;
   logic [MAX_GATES-1:0]    enter_pad, exit_pad;
   logic [3:0]              n_enter, n_exit;
   logic signed [CNT_W+3:0] sum_s;

   // Entries and exits from all gates net out before the clamp.
   always_comb begin
      enter_pad                = '0;
      exit_pad                 = '0;
      enter_pad[NUM_GATES-1:0] = enter_nxt;
      exit_pad[NUM_GATES-1:0]  = exit_nxt;
      n_enter     = popcount8(enter_pad);
      n_exit      = popcount8(exit_pad);
      sum_s       = $signed({4'b0000, count_q})
                  + $signed({{CNT_W{1'b0}}, n_enter})
                  - $signed({{CNT_W{1'b0}}, n_exit});
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (sum_s[CNT_W+3]) begin
         count_d     = '0;
         underflow_d = 1'b1;
      end else if (sum_s > CAP_S) begin
         count_d    = CAP_C;
         overflow_d = 1'b1;
      end else begin
         count_d = sum_s[CNT_W-1:0];
      end
      full_d  = (count_d == CAP_C);
      empty_d = (count_d == '0);
   end

`ifdef PARKING_LOT_GATE_BLOCK_EN
   always_comb begin
      gate_block_d = '0;
      for (int g = 0; g < NUM_GATES; g++)
         gate_block_d[g] = full_d | (in_nxt[g] & (count_d == CAP_C));
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifdef PARKING_LOT_GATE_BLOCK_EN
         gate_block_q <= '0;
`endif
      end else begin
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
`ifdef PARKING_LOT_GATE_BLOCK_EN
         gate_block_q <= gate_block_d;
`endif
      end
   end

   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`ifdef PARKING_LOT_GATE_BLOCK_EN
   assign gate_block = gate_block_q;
`endif

endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Directed bench for parking_lot_occupancy (CAPACITY=3, two gates) with a
// path-walking reference model checked every cycle plus literal spot checks.
module tb_parking_lot_occupancy;

   localparam int NG  = 2;
   localparam int CAP = 3;
   localparam int CW  = 4;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic [NG-1:0] a = '0, b = '0;
   logic [NG-1:0] enter, exit;
   logic [CW-1:0] count;
   logic          full, empty, overflow, underflow;
`ifdef PARKING_LOT_GATE_BLOCK_EN
   logic [NG-1:0] gate_block;
`endif

   int vectors = 0;
   int miscompares = 0;

   parking_lot_occupancy #(.NUM_GATES(NG), .CAPACITY(CAP), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .enter     (enter),
      .exit      (exit),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
`ifdef PARKING_LOT_GATE_BLOCK_EN
      .gate_block(gate_block),
`endif
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   // Model: a gate walks the path 00-a-ab-b-00 (entry) or 00-b-ab-a-00 (exit)
   // one neighbouring pattern at a time; any jump abandons the passage.
   int          m_dir[NG];
   int          m_pos[NG];
   int          m_count = 0;
   bit          m_ovf = 0, m_udf = 0;
   bit [NG-1:0] m_enter = '0, m_exit = '0;

   function automatic int path_idx(int dir, bit [1:0] p);
      if (p == 2'b11) return 2;
      if (dir > 0) return (p == 2'b10) ? 1 : 3;
      return (p == 2'b01) ? 1 : 3;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int g = 0; g < NG; g++) begin m_pos[g] = 0; m_dir[g] = 0; end
         m_count = 0; m_ovf = 0; m_udf = 0; m_enter = '0; m_exit = '0;
      end else begin
         int e, x, nxt, k;
         bit [1:0] p;
         e = 0; x = 0;
         m_enter = '0; m_exit = '0;
         for (int g = 0; g < NG; g++) begin
            p = {a[g], b[g]};
            if (m_pos[g] == 0) begin
               if (p == 2'b10) begin m_dir[g] = 1;  m_pos[g] = 1; end
               else if (p == 2'b01) begin m_dir[g] = -1; m_pos[g] = 1; end
            end else if (p == 2'b00) begin
               if (m_pos[g] == 3) begin
                  if (m_dir[g] > 0) begin m_enter[g] = 1; e++; end
                  else begin m_exit[g] = 1; x++; end
               end
               m_pos[g] = 0;
            end else begin
               k = path_idx(m_dir[g], p);
               if (k == m_pos[g] + 1 || k == m_pos[g] - 1) m_pos[g] = k;
               else if (k != m_pos[g]) m_pos[g] = 0;
            end
         end
         nxt = m_count + e - x;
         if (nxt > CAP) begin m_ovf = 1; nxt = CAP; end
         else if (nxt < 0) begin m_udf = 1; nxt = 0; end
         m_count = nxt;
      end
   end

   always @(negedge clk) begin
      bit bad;
      vectors++;
      bad = (enter !== m_enter) || (exit !== m_exit) || (count !== CW'(m_count))
         || (full !== (m_count == CAP)) || (empty !== (m_count == 0))
         || (overflow !== m_ovf) || (underflow !== m_udf);
`ifdef PARKING_LOT_GATE_BLOCK_EN
      if (gate_block !== {NG{m_count == CAP}}) bad = 1;
`endif
      if (bad) begin
         miscompares++;
         $display("FAIL cycle_model t=%0t: got enter=%b exit=%b count=%0d full=%b empty=%b ovf=%b udf=%b, want enter=%b exit=%b count=%0d ovf=%b udf=%b",
                  $time, enter, exit, count, full, empty, overflow, underflow,
                  m_enter, m_exit, m_count, m_ovf, m_udf);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step(input bit [1:0] p0, input bit [1:0] p1);
      {a[0], b[0]} = p0;
      {a[1], b[1]} = p1;
      @(posedge clk);
      #3;
   endtask

   task automatic entry0();
      step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00); step(2'b00, 2'b00);
   endtask

   task automatic exit1();
      step(2'b00, 2'b01); step(2'b00, 2'b11); step(2'b00, 2'b10); step(2'b00, 2'b00);
   endtask

   task automatic both();
      step(2'b10, 2'b01); step(2'b11, 2'b11); step(2'b01, 2'b10); step(2'b00, 2'b00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2'b00, 2'b00);
      reset = 1'b0;
      step(2'b00, 2'b00);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #3;
      chk("reset_count", count, 0);
      chk("reset_empty", empty, 1);
      reset = 1'b0;
      step(2'b00, 2'b00);

      entry0();
      chk("entry_pulse", enter[0], 1);
      chk("entry_count", count, 1);
      chk("entry_empty_fell", empty, 0);
      step(2'b00, 2'b00);
      chk("entry_pulse_width", enter[0], 0);

      exit1();
      chk("exit_pulse", exit[1], 1);
      chk("exit_count", count, 0);
      chk("exit_empty", empty, 1);

      step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b10, 2'b00); step(2'b00, 2'b00);
      chk("abort_no_pulse", enter[0], 0);
      chk("abort_count", count, 0);

      for (int i = 0; i < 4; i++) entry0();
      chk("sat_count", count, 3);
      chk("sat_full", full, 1);
      chk("sat_overflow", overflow, 1);
      step(2'b00, 2'b00);
      chk("overflow_sticky", overflow, 1);

      do_reset();
      chk("reset_clears_overflow", overflow, 0);
      entry0(); entry0();
      both();
      chk("net_count", count, 2);
      chk("net_enter_exit", {enter, exit}, 4'b0110);
      chk("net_no_flags", {overflow, underflow}, 0);

      entry0();
      both();
      chk("net_at_full_count", count, 3);
      chk("net_at_full_no_ovf", overflow, 0);

      for (int i = 0; i < 4; i++) exit1();
      chk("underflow_count", count, 0);
      chk("underflow_flag", underflow, 1);

      do_reset();
      step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00);
      reset = 1'b1;
      step(2'b01, 2'b00);
      chk("mid_reset_count", count, 0);
      reset = 1'b0;
      step(2'b00, 2'b00);
      chk("mid_reset_no_pulse", enter[0], 0);
      chk("mid_reset_underflow", underflow, 0);
      step(2'b00, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
